serial_subtractor: RTL
======================

// Module: serial_subtractor
// PURPOSE
//   Bit-serial, multi-cycle subtractor. It computes D = A - B - BI, LSB first, at one bit per clock.
//   It is the subtracting counterpart of the parallel adder: it uses the same operand, width and
//   carry/borrow conventions, but trades area for latency.
//   Used by iterative datapaths (divider, compare units) that issue one operation and wait for DONE.
// PARAMETERS
//   DATA_WIDTH  8  operand/result width in bits; legal range >= 2
// PORTS
//   CLK    in   1           clock, rising-edge active
//   RST    in   1           reset, asynchronous, active-high
//   START  in   1           request; sampled on CLK rising edge
//   A      in   DATA_WIDTH  minuend; sampled only when START is accepted
//   B      in   DATA_WIDTH  subtrahend; sampled only when START is accepted
//   BI     in   1           borrow in; sampled only when START is accepted
//   BUSY   out  1           high while an operation is in RUN
//   DONE   out  1           one-cycle pulse; D/BO valid from this cycle on
//   D      out  DATA_WIDTH  difference (A - B - BI) mod 2^DATA_WIDTH
//   BO     out  1           borrow out; 1 iff A < B + BI (unsigned)
// BEHAVIOUR
//   Interface: one clock (CLK); reset RST is asynchronous and active-high.
//   Reset: while RST=1, state=IDLE and BUSY=0, DONE=0, D=0, BO=0; all internal shift and count
//     registers are cleared.
//   Reset mid-operation: aborts the operation and clears all outputs; no DONE pulse is produced.
//   FSM states: IDLE, RUN, FIN.
//     IDLE -> RUN on START=1.
//       Latch A and B into shift registers; borrow register <= BI; bit counter <= 0.
//     RUN: each cycle, process operand bit i = counter. Let a, b = the current LSBs and br = borrow.
//       d_i = a ^ b ^ br
//       br' = (~a & b) | (~(a ^ b) & br)
//       Shift d_i into the MSB of the result register; shift the operands right; counter++.
//       RUN -> FIN on the edge that processes bit DATA_WIDTH-1.
//         On that edge: D <= result register; BO <= final br'.
//     FIN: DONE=1 for exactly this one cycle.
//       FIN -> RUN if START=1 (back-to-back; new operands latched as in IDLE).
//       FIN -> IDLE otherwise.
//   Latency: START accepted at edge t0 -> DONE=1 in the cycle following edge t0+DATA_WIDTH.
//     BUSY=1 for DATA_WIDTH cycles. Throughput is one result per DATA_WIDTH+1 cycles.
//   START handling: START is ignored while in RUN. A, B and BI may change freely after acceptance.
//   D and BO hold the last completed result until the next completion or reset.
//     They do not change during RUN.
//   Arithmetic: pure unsigned modulo-2^DATA_WIDTH arithmetic; no saturation.
//     Cross-check identity: D == A + ~B + ~BI (mod 2^DATA_WIDTH), and BO == ~CO of that sum.
//   Boundaries:
//     A == B with BI=0 -> D=0, BO=0.
//     A == B with BI=1 -> D = all ones, BO=1.
//     A=0, B = all ones, BI=1 -> D=0, BO=1 (maximum borrow chain).
// TESTING  (DATA_WIDTH=8; each check is made in the DONE cycle)
//   1. A=135, B=16, BI=0 -> D=119, BO=0.
//      Also: DONE occurs exactly 8 edges after the START edge; BUSY is high for 8 cycles.
//   2. A=135, B=16, BI=1 -> D=118, BO=0.
//      Then A=16, B=135, BI=0 -> D=137, BO=1.
//   3. A=0, B=0, BI=1 -> D=255, BO=1.
//      Then A=0, B=255, BI=1 -> D=0, BO=1.
//   4. Start A=200, B=100. Pulse START with A=1, B=1 mid-RUN -> the pulse is ignored; D=100, BO=0.
//      D keeps its previous value throughout RUN.
//   5. Back-to-back: hold START=1 through the FIN cycle with A=50, B=60 ->
//      the second DONE arrives 9 cycles after the first, with D=246, BO=1.
//   6. Assert RST asynchronously (mid-cycle) during RUN -> BUSY, DONE, D and BO go to 0 immediately.
//      No DONE follows. The next START runs normally.
//   Also: a random sweep of 1000 {A, B, BI} triples checked against A - B - BI on a 9-bit reference.

Source files
------------

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: D = A - B - BI, LSB first, one bit per clock.
// Ports: CLK/RST, START/A/B/BI request, BUSY/DONE status, D/BO result.
module serial_subtractor #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  START,
  input  logic [DATA_WIDTH-1:0] A,
  input  logic [DATA_WIDTH-1:0] B,
  input  logic                  BI,
  output logic                  BUSY,
  output logic                  DONE,
  output logic [DATA_WIDTH-1:0] D,
  output logic                  BO
);

  localparam int CW = $clog2(DATA_WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIN
  } state_t;

  state_t state, state_nx;

  logic [DATA_WIDTH-1:0] a_sr, b_sr, r_sr, d_q;
  logic [CW-1:0]         cnt;
  logic                  br, bo_q;
  logic                  a_b, b_b, d_bit, br_nx;
  logic                  last, load;

  assign a_b   = a_sr[0];
  assign b_b   = b_sr[0];
  assign d_bit = a_b ^ b_b ^ br;
  assign br_nx = (~a_b & b_b) | (~(a_b ^ b_b) & br);
  assign last  = (cnt == CW'(DATA_WIDTH - 1));

  always_comb begin
    state_nx = state;
    load     = 1'b0;
    unique case (state)
      IDLE: begin
        if (START) begin
          state_nx = RUN;
          load     = 1'b1;
        end
      end
      RUN: begin
        if (last) state_nx = FIN;
      end
      FIN: begin
        if (START) begin
          state_nx = RUN;
          load     = 1'b1;
        end else begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= IDLE;
    else     state <= state_nx;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      a_sr <= '0;
      b_sr <= '0;
      r_sr <= '0;
      br   <= 1'b0;
      cnt  <= '0;
      d_q  <= '0;
      bo_q <= 1'b0;
    end else if (load) begin
      a_sr <= A;
      b_sr <= B;
      br   <= BI;
      r_sr <= '0;
      cnt  <= '0;
    end else if (state == RUN) begin
      a_sr <= a_sr >> 1;
      b_sr <= b_sr >> 1;
      br   <= br_nx;
      r_sr <= {d_bit, r_sr[DATA_WIDTH-1:1]};
      cnt  <= cnt + CW'(1);
      // Result becomes visible only once the whole word is done.
      if (last) begin
        d_q  <= {d_bit, r_sr[DATA_WIDTH-1:1]};
        bo_q <= br_nx;
      end
    end
  end

  assign BUSY = (state == RUN);
  assign DONE = (state == FIN);
  assign D    = d_q;
  assign BO   = bo_q;

endmodule
